// File: rtl/pce_pad_pkg.sv
// Shared constants and nibble helpers for the PC Engine multitap responder.
// Button indices follow the native pad word: i, ii, select, start, dirs, iii..vi.
package pce_pad_pkg;

  localparam int BTN_I      = 0;
  localparam int BTN_II     = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_RIGHT  = 5;
  localparam int BTN_DOWN   = 6;
  localparam int BTN_LEFT   = 7;
  localparam int BTN_III    = 8;
  localparam int BTN_IV     = 9;
  localparam int BTN_V      = 10;
  localparam int BTN_VI     = 11;

  localparam int BTNS_PER_PAD = 12;
  localparam int MAX_PORTS    = 5;

  localparam logic [3:0] NIB_NO_PAD = 4'hF;
  localparam logic [3:0] NIB_6B_ID  = 4'h0;
  localparam logic [3:0] NIB_CLR    = 4'h0;

  typedef logic [BTNS_PER_PAD-1:0] pad_t;

  // All nibbles are MSB-first in the order the console expects on D[3:0].
  function automatic logic [3:0] dir_nib(input pad_t b);
    return {b[BTN_UP], b[BTN_RIGHT], b[BTN_DOWN], b[BTN_LEFT]};
  endfunction

  function automatic logic [3:0] std_nib(input pad_t b);
    return {b[BTN_I], b[BTN_II], b[BTN_SELECT], b[BTN_START]};
  endfunction

  function automatic logic [3:0] ext_nib(input pad_t b);
    return {b[BTN_III], b[BTN_IV], b[BTN_V], b[BTN_VI]};
  endfunction

endpackage

// File: rtl/pce_sync_edge.sv
// Synchroniser for an asynchronous console strobe, giving a registered level
// plus one-cycle rise/fall pulses that are aligned with that level.
module pce_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] chain_q;
  logic                   level_q;
  logic                   rise_q;
  logic                   fall_q;

  // Pulses are registered alongside the level so that downstream logic sees
  // the new level and its edge pulse in the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      chain_q <= {SYNC_STAGES{RESET_VAL}};
      level_q <= RESET_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], async_i};
      level_q <= chain_q[SYNC_STAGES-1];
      rise_q  <= chain_q[SYNC_STAGES-1] & ~level_q;
      fall_q  <= ~chain_q[SYNC_STAGES-1] & level_q;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/pce_multitap_pad.sv
// PC Engine multitap responder: walks 1..NUM_PORTS pads on SEL rises, toggles the
// 6-button bank on every CLR rise, and serves nibbles from a per-scan snapshot.
module pce_multitap_pad
  import pce_pad_pkg::*;
#(
  parameter  int NUM_PORTS   = 5,
  parameter  int SYNC_STAGES = 2,
  localparam int PW          = $clog2(NUM_PORTS + 1),
  localparam int SW          = NUM_PORTS * BTNS_PER_PAD
) (
  input  logic                 system_clock,
  input  logic                 reset,
  input  logic                 sel,
  input  logic                 clr,
  input  logic [NUM_PORTS-1:0] six_button,
  input  logic [SW-1:0]        pad_buttons,
  output logic [3:0]           d,
  output logic [PW-1:0]        port_idx,
  output logic                 bank
);

  logic s_sel, sel_rise, sel_fall_unused;
  logic s_clr, clr_rise, clr_fall;

  pce_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b0)
  ) u_sel_sync (
    .clk_i   (system_clock),
    .rst_i   (reset),
    .async_i (sel),
    .level_o (s_sel),
    .rise_o  (sel_rise),
    .fall_o  (sel_fall_unused)
  );

  pce_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b0)
  ) u_clr_sync (
    .clk_i   (system_clock),
    .rst_i   (reset),
    .async_i (clr),
    .level_o (s_clr),
    .rise_o  (clr_rise),
    .fall_o  (clr_fall)
  );

  logic [PW-1:0] idx_q, idx_d;
  logic          bank_q, bank_d;
  logic [SW-1:0] snap_q, snap_d;
  logic [3:0]    d_q, d_d;
  pad_t          pad_sel;
  logic          six_sel;

  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      idx_q  <= '0;
      bank_q <= 1'b0;
      snap_q <= '1;
      d_q    <= NIB_NO_PAD;
    end else begin
      idx_q  <= idx_d;
      bank_q <= bank_d;
      snap_q <= snap_d;
      d_q    <= d_d;
    end
  end

  // One event per cycle: clr rise beats clr fall beats sel rise.
  always_comb begin
    idx_d  = idx_q;
    bank_d = bank_q;
    snap_d = snap_q;
    if (clr_rise) begin
      idx_d  = '0;
      bank_d = ~bank_q;
    end else if (clr_fall) begin
      snap_d = pad_buttons;
    end else if (sel_rise && !s_clr) begin
      if (idx_q != PW'(NUM_PORTS)) idx_d = idx_q + PW'(1);
    end
  end

  always_comb begin
    pad_sel = '1;
    six_sel = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (idx_d == PW'(p)) begin
        pad_sel = snap_d[p*BTNS_PER_PAD +: BTNS_PER_PAD];
        six_sel = six_button[p];
      end
    end
  end

  // Computed from next-state pointer/bank/snapshot so d moves on the event edge.
  always_comb begin
    d_d = NIB_NO_PAD;
    if (s_clr) begin
      d_d = NIB_CLR;
    end else if (idx_d == PW'(NUM_PORTS)) begin
      d_d = NIB_NO_PAD;
    end else if (six_sel && bank_d) begin
      d_d = s_sel ? NIB_6B_ID : ext_nib(pad_sel);
    end else begin
      d_d = s_sel ? dir_nib(pad_sel) : std_nib(pad_sel);
    end
  end

  assign d        = d_q;
  assign port_idx = idx_q;
  assign bank     = bank_q;

endmodule

// File: tb/tb_pce_multitap_pad.sv
// Bench for pce_multitap_pad: directed vector table, hand-written timing/reset
// sequences, and random console activity checked against a scan-level model.
module tb_pce_multitap_pad;

  localparam int NP = 5;
  localparam int PW = $clog2(NP + 1);
  localparam int SW = NP * 12;
  localparam int SETTLE = 5;

  logic          system_clock = 1'b0;
  logic          reset        = 1'b0;
  logic          sel          = 1'b0;
  logic          clr          = 1'b0;
  logic [NP-1:0] six_button   = '0;
  logic [SW-1:0] pad_buttons  = '1;
  logic [3:0]    d;
  logic [PW-1:0] port_idx;
  logic          bank;

  int n_checks = 0;
  int n_fail   = 0;

  pce_multitap_pad #(
    .NUM_PORTS   (NP),
    .SYNC_STAGES (2)
  ) dut (
    .system_clock (system_clock),
    .reset        (reset),
    .sel          (sel),
    .clr          (clr),
    .six_button   (six_button),
    .pad_buttons  (pad_buttons),
    .d            (d),
    .port_idx     (port_idx),
    .bank         (bank)
  );

  // ---------------- clock / watchdog ----------------
  always #5 system_clock = ~system_clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [3:0] ed, input int eidx, input bit ebank);
    chk({name, ".d"}, 64'(d), 64'(ed));
    chk({name, ".idx"}, 64'(port_idx), 64'(eidx));
    chk({name, ".bank"}, 64'(bank), 64'(ebank));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge system_clock);
    #1;
  endtask

  task automatic drive_pins(input logic c, input logic s);
    @(posedge system_clock);
    #1;
    clr = c;
    sel = s;
    tick(SETTLE);
  endtask

  // ---------------- reference model ----------------
  int            m_idx;
  bit            m_bank;
  logic [SW-1:0] m_snap;
  logic          m_clr, m_sel;

  function automatic logic [3:0] model_d(input logic c, input logic s, input int idx,
                                         input bit bk, input logic [SW-1:0] snap,
                                         input logic [NP-1:0] six);
    logic [11:0] b;
    if (c) return 4'h0;
    if (idx == NP) return 4'hF;
    b = snap[idx*12 +: 12];
    // bits: 0 i, 1 ii, 2 select, 3 start, 4 up, 5 right, 6 down, 7 left, 8 iii .. 11 vi
    if (six[idx] && bk) return s ? 4'h0 : {b[8], b[9], b[10], b[11]};
    return s ? {b[4], b[5], b[6], b[7]} : {b[0], b[1], b[2], b[3]};
  endfunction

  task automatic model_pins(input logic c, input logic s);
    if (c && !m_clr) begin
      m_idx  = 0;
      m_bank = ~m_bank;
    end else if (!c && m_clr) begin
      m_snap = pad_buttons;
    end else if (s && !m_sel && !c) begin
      if (m_idx < NP) m_idx = m_idx + 1;
    end
    m_clr = c;
    m_sel = s;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [NP-1:0] six;
    logic [SW-1:0] pads;
    logic          c;
    logic          s;
    logic [3:0]    ed;
    int            eidx;
    bit            ebank;
  } vec_t;

  vec_t vecs[31];

  function automatic vec_t mk(input logic [NP-1:0] six, input logic [SW-1:0] pads,
                              input logic c, input logic s, input logic [3:0] ed,
                              input int eidx, input bit ebank);
    vec_t v;
    v.six = six; v.pads = pads; v.c = c; v.s = s;
    v.ed = ed; v.eidx = eidx; v.ebank = ebank;
    return v;
  endfunction

  initial begin
    logic [SW-1:0] all_up, p2_up, p0_iii, p_mix, one;
    logic [3:0]    d_before;
    one    = 1;
    all_up = '1;
    p2_up  = all_up & ~(one << 28);
    p0_iii = all_up & ~(one << 8);
    p_mix  = p0_iii & ~(one << 17) & ~(one << 12);

    // 2-button scan, port 2 up pressed, pointer saturation
    vecs[0]  = mk(5'b00000, all_up, 1, 1, 4'h0, 0, 1);
    vecs[1]  = mk(5'b00000, p2_up,  1, 1, 4'h0, 0, 1);
    vecs[2]  = mk(5'b00000, p2_up,  0, 1, 4'hF, 0, 1);
    vecs[3]  = mk(5'b00000, p2_up,  0, 0, 4'hF, 0, 1);
    vecs[4]  = mk(5'b00000, p2_up,  0, 1, 4'hF, 1, 1);
    vecs[5]  = mk(5'b00000, p2_up,  0, 0, 4'hF, 1, 1);
    vecs[6]  = mk(5'b00000, p2_up,  0, 1, 4'b0111, 2, 1);
    vecs[7]  = mk(5'b00000, p2_up,  0, 0, 4'hF, 2, 1);
    vecs[8]  = mk(5'b00000, p2_up,  0, 1, 4'hF, 3, 1);
    vecs[9]  = mk(5'b00000, p2_up,  0, 0, 4'hF, 3, 1);
    vecs[10] = mk(5'b00000, p2_up,  0, 1, 4'hF, 4, 1);
    vecs[11] = mk(5'b00000, p2_up,  0, 0, 4'hF, 4, 1);
    vecs[12] = mk(5'b00000, p2_up,  0, 1, 4'hF, 5, 1);
    vecs[13] = mk(5'b00000, p2_up,  0, 0, 4'hF, 5, 1);
    vecs[14] = mk(5'b00000, p2_up,  0, 1, 4'hF, 5, 1);
    // 6-button port 0, bank 0 scan then bank 1 scan with simultaneous clr/sel rise
    vecs[15] = mk(5'b00001, p0_iii, 1, 1, 4'h0, 0, 0);
    vecs[16] = mk(5'b00001, p0_iii, 0, 1, 4'hF, 0, 0);
    vecs[17] = mk(5'b00001, p0_iii, 0, 0, 4'hF, 0, 0);
    vecs[18] = mk(5'b00001, p_mix,  1, 1, 4'h0, 0, 1);
    vecs[19] = mk(5'b00001, p_mix,  0, 1, 4'h0, 0, 1);
    vecs[20] = mk(5'b00001, p_mix,  0, 0, 4'b0111, 0, 1);
    // port 1 in 2-button mode with bank 1
    vecs[21] = mk(5'b00001, p_mix,  0, 1, 4'b1011, 1, 1);
    vecs[22] = mk(5'b00001, p_mix,  0, 0, 4'b0111, 1, 1);
    vecs[23] = mk(5'b00001, p_mix,  0, 1, 4'hF, 2, 1);
    // next scan, bank 0: port 0 gives standard nibbles
    vecs[24] = mk(5'b00001, p_mix,  1, 1, 4'h0, 0, 0);
    vecs[25] = mk(5'b00001, p_mix,  0, 1, 4'hF, 0, 0);
    vecs[26] = mk(5'b00001, p_mix,  0, 0, 4'hF, 0, 0);
    // sel rise while clr high is ignored; mid-scan button change is invisible
    vecs[27] = mk(5'b00001, p_mix,  1, 0, 4'h0, 0, 1);
    vecs[28] = mk(5'b00001, p_mix,  1, 1, 4'h0, 0, 1);
    vecs[29] = mk(5'b00001, p_mix,  0, 1, 4'h0, 0, 1);
    vecs[30] = mk(5'b00001, all_up, 0, 0, 4'b0111, 0, 1);

    // ---- reset state (sel high, clr low) ----
    clr = 1'b0;
    sel = 1'b1;
    reset = 1'b1;
    tick(2);
    chk_all("reset", 4'hF, 0, 0);
    @(posedge system_clock);
    #1;
    reset = 1'b0;
    tick(3);
    chk("post_reset.d", 64'(d), 64'hF);
    chk("post_reset.idx", 64'(port_idx), 64'd0);
    tick(SETTLE);

    // ---- table ----
    for (int i = 0; i < 31; i++) begin
      six_button  = vecs[i].six;
      pad_buttons = vecs[i].pads;
      drive_pins(vecs[i].c, vecs[i].s);
      chk_all($sformatf("vec%0d", i), vecs[i].ed, vecs[i].eidx, vecs[i].ebank);
    end

    // ---- reset mid-scan: reach port 3 with bank 1, then async reset ----
    drive_pins(0, 1);
    drive_pins(0, 0);
    drive_pins(0, 1);
    drive_pins(0, 0);
    drive_pins(0, 1);
    chk("midscan.idx", 64'(port_idx), 64'd3);
    chk("midscan.bank", 64'(bank), 64'd1);
    @(posedge system_clock);
    #3;
    reset = 1'b1;
    #1;
    chk_all("async_reset", 4'hF, 0, 0);

    // ---- strobe latency: clr visible on d exactly 3 edges after first sample ----
    clr = 1'b0;
    sel = 1'b0;
    six_button  = '0;
    pad_buttons = '1;
    @(posedge system_clock);
    #1;
    reset = 1'b0;
    tick(SETTLE);
    d_before = d;
    chk("latency.pre", 64'(d_before), 64'hF);
    clr = 1'b1;
    tick(3);
    chk("latency.k+2", 64'(d), 64'hF);
    tick(1);
    chk("latency.k+3", 64'(d), 64'h0);
    chk("latency.bank", 64'(bank), 64'd1);
    drive_pins(0, 0);

    // ---- reset released while clr is high: exactly one rise ----
    clr = 1'b1;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(8);
    chk_all("clr_high_release", 4'h0, 0, 1);

    // ---- randomized console activity against the model ----
    clr = 1'b0;
    sel = 1'b0;
    six_button  = '0;
    pad_buttons = '1;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(SETTLE);
    m_idx = 0; m_bank = 0; m_snap = '1; m_clr = 0; m_sel = 0;
    for (int n = 0; n < 250; n++) begin
      int op;
      logic nc, ns;
      op = $urandom_range(0, 5);
      nc = m_clr;
      ns = m_sel;
      case (op)
        0, 1, 5: ns = ~m_sel;
        2:       nc = ~m_clr;
        3:       pad_buttons = SW'({$urandom(), $urandom()});
        default: six_button = NP'($urandom_range(0, (1 << NP) - 1));
      endcase
      model_pins(nc, ns);
      drive_pins(nc, ns);
      chk_all($sformatf("rand%0d", n),
              model_d(m_clr, m_sel, m_idx, m_bank, m_snap, six_button), m_idx, m_bank);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
